// File: rtl/mux_2to1_port_pkg.sv
// rtl/mux_2to1_port_pkg.sv - shared NoC widths, flit-type encodings and enable constants
package mux_2to1_port_pkg;

  localparam int DATAW_DEF = 36;
  localparam int VCHW_DEF  = 2;
  localparam int PORTW_DEF = 5;

  typedef enum logic [1:0] {
    FLIT_NONE = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_DATA = 2'b10,
    FLIT_TAIL = 2'b11
  } flit_type_e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/mux_sel_decode.sv
// rtl/mux_sel_decode.sv - one-hot port select to (port index, none, error)
module mux_sel_decode (
  input  logic [1:0] sel,
  output logic       port_idx,
  output logic       none,
  output logic       err
);

  // 2'b11 falls back to port 0, so port_idx is only 1 for a clean port-1 select
  always_comb begin
    port_idx = (sel == 2'b10);
    none     = (sel == 2'b00);
    err      = (sel == 2'b11);
  end

endmodule

// File: rtl/mux_2to1_port.sv
// rtl/mux_2to1_port.sv - registered two-input flit mux with forwarded-flit counter
module mux_2to1_port
  import mux_2to1_port_pkg::*;
#(
  parameter int DATAW = DATAW_DEF,
  parameter int VCHW  = VCHW_DEF,
  parameter int PORTW = PORTW_DEF,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DATAW-1:0] idata_0,
  input  logic             ivalid_0,
  input  logic [VCHW-1:0]  ivch_0,
  input  logic [DATAW-1:0] idata_1,
  input  logic             ivalid_1,
  input  logic [VCHW-1:0]  ivch_1,
  input  logic [PORTW-1:0] sel,
  output logic [DATAW-1:0] odata,
  output logic             ovalid,
  output logic [VCHW-1:0]  ovch,
  output logic             sel_err,
  output logic [CNTW-1:0]  flit_cnt
);

  logic             port_idx;
  logic             sel_none;
  logic             sel_bad;
  logic [DATAW-1:0] next_data;
  logic             next_valid;
  logic [VCHW-1:0]  next_vch;
  logic             unused_sel_hi;

  assign unused_sel_hi = ^sel[PORTW-1:2];

  mux_sel_decode u_decode (
    .sel      (sel[1:0]),
    .port_idx (port_idx),
    .none     (sel_none),
    .err      (sel_bad)
  );

  // All three fields switch together so a flit is never assembled from both ports
  always_comb begin
    next_data  = '0;
    next_valid = DISABLE;
    next_vch   = '0;
    if (!sel_none) begin
      if (port_idx) begin
        next_data  = idata_1;
        next_valid = ivalid_1;
        next_vch   = ivch_1;
      end else begin
        next_data  = idata_0;
        next_valid = ivalid_0;
        next_vch   = ivch_0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      odata    <= '0;
      ovalid   <= DISABLE;
      ovch     <= '0;
      sel_err  <= DISABLE;
      flit_cnt <= '0;
    end else begin
      odata   <= next_data;
      ovalid  <= next_valid;
      ovch    <= next_vch;
      sel_err <= sel_bad;
      if (next_valid) flit_cnt <= flit_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_mux_2to1_port.sv
// tb/tb_mux_2to1_port.sv - directed self-checking bench for mux_2to1_port
module tb_mux_2to1_port;
  import mux_2to1_port_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [35:0] idata_0 = '0, idata_1 = '0;
  logic        ivalid_0 = 1'b0, ivalid_1 = 1'b0;
  logic [1:0]  ivch_0 = '0, ivch_1 = '0;
  logic [4:0]  sel = '0;
  logic [35:0] odata, w_odata;
  logic        ovalid, w_ovalid;
  logic [1:0]  ovch, w_ovch;
  logic        sel_err, w_sel_err;
  logic [15:0] flit_cnt;
  logic [3:0]  w_flit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_2to1_port dut (
    .clk(clk), .rst(rst),
    .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
    .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
    .sel(sel), .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .sel_err(sel_err), .flit_cnt(flit_cnt)
  );

  mux_2to1_port #(.CNTW(4)) dut_w (
    .clk(clk), .rst(rst),
    .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
    .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
    .sel(sel), .odata(w_odata), .ovalid(w_ovalid), .ovch(w_ovch),
    .sel_err(w_sel_err), .flit_cnt(w_flit_cnt)
  );

  function automatic logic [35:0] mk(flit_type_e t, int n);
    mk = {t, 34'(n)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel = 5'b00001; idata_0 = mk(FLIT_HEAD, 77); ivalid_0 = 1'b1; ivch_0 = 2'd3;
    idata_1 = mk(FLIT_DATA, 88); ivalid_1 = 1'b1; ivch_1 = 2'd1;
    tick(); tick();
    n_checks++;
    if ({odata, ovalid, ovch, sel_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%b/%h/%b want 0", odata, ovalid, ovch, sel_err);
    end
    n_checks++;
    if (flit_cnt !== 16'd0 || w_flit_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", flit_cnt, w_flit_cnt);
    end
    rst = 1'b0; sel = 5'b00000; ivalid_0 = 1'b0; ivalid_1 = 1'b0;
    tick();
  endtask

  task automatic send_p1_packet(input int base);
    int errs;
    logic [35:0] exp;
    flit_type_e t;
    errs = 0;
    for (int i = 0; i < 22; i++) begin
      t = (i == 0) ? FLIT_HEAD : (i == 21) ? FLIT_TAIL : FLIT_DATA;
      exp = mk(t, base + i);
      sel = 5'b00010;
      idata_1 = exp; ivalid_1 = 1'b1; ivch_1 = 2'd2;
      idata_0 = mk(FLIT_DATA, 5000 + base + i); ivalid_0 = 1'b1; ivch_0 = 2'd1;
      tick();
      n_checks++;
      if (odata !== exp || ovch !== 2'd2 || ovalid !== 1'b1) begin
        n_fail++; errs++;
        if (errs < 4) $display("FAIL p1_flit[%0d]: got %h/%h/%b want %h/2/1", i, odata, ovch, ovalid, exp);
      end
    end
  endtask

  task automatic test_port1_packet();
    send_p1_packet(0);
    n_checks++;
    if (flit_cnt !== 16'd22) begin
      n_fail++; $display("FAIL p1_cnt: got %0d want 22", flit_cnt);
    end
  endtask

  task automatic test_idle_gaps();
    int gap_errs;
    gap_errs = 0;
    for (int p = 1; p < 10; p++) begin
      for (int g = 0; g < 7; g++) begin
        sel = 5'b00010;
        idata_1 = mk(FLIT_NONE, 900 + g); ivalid_1 = 1'b0; ivch_1 = 2'd3;
        ivalid_0 = 1'b1;
        tick();
        n_checks++;
        if (ovalid !== 1'b0 || odata !== mk(FLIT_NONE, 900 + g) || ovch !== 2'd3) begin
          n_fail++; gap_errs++;
          if (gap_errs < 4) $display("FAIL gap_idle[%0d]: got v=%b d=%h c=%h want v=0 d=%h c=3", g, ovalid, odata, ovch, mk(FLIT_NONE, 900 + g));
        end
      end
      send_p1_packet(p * 100);
    end
    n_checks++;
    if (flit_cnt !== 16'd220) begin
      n_fail++; $display("FAIL gap_cnt: got %0d want 220", flit_cnt);
    end
  endtask

  task automatic test_mid_switch();
    logic [35:0] exp;
    logic [1:0]  exp_vch;
    for (int i = 0; i < 8; i++) begin
      sel = (i < 4) ? 5'b00001 : 5'b00010;
      idata_0 = mk(FLIT_DATA, 300 + i); ivalid_0 = 1'b1; ivch_0 = 2'd1;
      idata_1 = mk(FLIT_DATA, 600 + i); ivalid_1 = 1'b1; ivch_1 = 2'd2;
      exp     = (i < 4) ? mk(FLIT_DATA, 300 + i) : mk(FLIT_DATA, 600 + i);
      exp_vch = (i < 4) ? 2'd1 : 2'd2;
      tick();
      n_checks++;
      if (odata !== exp || ovch !== exp_vch || ovalid !== 1'b1) begin
        n_fail++; $display("FAIL switch[%0d]: got %h/%h/%b want %h/%h/1", i, odata, ovch, ovalid, exp, exp_vch);
      end
    end
    n_checks++;
    if (flit_cnt !== 16'd228) begin
      n_fail++; $display("FAIL switch_cnt: got %0d want 228", flit_cnt);
    end
  endtask

  task automatic test_illegal_sel();
    idata_0 = mk(FLIT_HEAD, 41); ivalid_0 = 1'b1; ivch_0 = 2'd0;
    idata_1 = mk(FLIT_TAIL, 42); ivalid_1 = 1'b1; ivch_1 = 2'd3;
    sel = 5'b00011;
    tick();
    n_checks++;
    if (odata !== mk(FLIT_HEAD, 41) || ovch !== 2'd0 || sel_err !== 1'b1) begin
      n_fail++; $display("FAIL sel_11: got %h/%h err=%b want %h/0 err=1", odata, ovch, sel_err, mk(FLIT_HEAD, 41));
    end
    sel = 5'b00001;
    tick();
    n_checks++;
    if (sel_err !== 1'b0) begin
      n_fail++; $display("FAIL sel_err_clear: got %b want 0", sel_err);
    end
    sel = 5'b00000;
    tick();
    n_checks++;
    if (ovalid !== 1'b0 || odata !== 36'd0 || ovch !== 2'd0 || sel_err !== 1'b0) begin
      n_fail++; $display("FAIL sel_00: got %h/%b/%h err=%b want 0/0/0 err=0", odata, ovalid, ovch, sel_err);
    end
    sel = 5'b10110;
    tick();
    n_checks++;
    if (odata !== mk(FLIT_TAIL, 42) || ovch !== 2'd3 || ovalid !== 1'b1 || sel_err !== 1'b0) begin
      n_fail++; $display("FAIL sel_hi_ignored: got %h/%h/%b err=%b want %h/3/1 err=0", odata, ovch, ovalid, sel_err, mk(FLIT_TAIL, 42));
    end
    n_checks++;
    if (flit_cnt !== 16'd231) begin
      n_fail++; $display("FAIL illegal_cnt: got %0d want 231", flit_cnt);
    end
  endtask

  task automatic test_wrap_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    sel = 5'b00001; ivalid_0 = 1'b1; ivch_0 = 2'd1;
    for (int i = 0; i < 15; i++) begin
      idata_0 = mk(FLIT_DATA, 700 + i);
      tick();
    end
    n_checks++;
    if (w_flit_cnt !== 4'd15) begin
      n_fail++; $display("FAIL wrap_max: got %0d want 15", w_flit_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      idata_0 = mk(FLIT_DATA, 720 + i);
      tick();
    end
    n_checks++;
    if (w_flit_cnt !== 4'd1 || flit_cnt !== 16'd17) begin
      n_fail++; $display("FAIL wrap_cnt: got %0d/%0d want 1/17", w_flit_cnt, flit_cnt);
    end
    rst = 1'b1; idata_0 = mk(FLIT_DATA, 730);
    tick();
    n_checks++;
    if ({odata, ovalid, ovch, sel_err} !== '0 || flit_cnt !== 16'd0 || w_flit_cnt !== 4'd0) begin
      n_fail++; $display("FAIL midpkt_reset: got %h/%b/%h/%b cnt %0d/%0d want all 0", odata, ovalid, ovch, sel_err, flit_cnt, w_flit_cnt);
    end
    rst = 1'b0; idata_0 = mk(FLIT_TAIL, 731);
    tick();
    n_checks++;
    if (odata !== mk(FLIT_TAIL, 731) || ovalid !== 1'b1 || flit_cnt !== 16'd1) begin
      n_fail++; $display("FAIL resume: got %h/%b cnt %0d want %h/1 cnt 1", odata, ovalid, flit_cnt, mk(FLIT_TAIL, 731));
    end
  endtask

  initial begin
    test_reset();
    test_port1_packet();
    test_idle_gaps();
    test_mid_switch();
    test_illegal_sel();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_2to1_port.md
# mux_2to1_port

Two-input flit multiplexer for the router output stage. Each cycle it forwards one input port's flit (data, valid, virtual channel) to a single output port, as chosen by a one-hot select vector from the switch allocator. The output is registered. The block also keeps a forwarded-flit counter and flags illegal selects, so it can be characterized for energy on its own.

## Interface
- `DATAW` — default 36 — flit width; flit type lives in the top 2 bits and is not interpreted here.
- `VCHW` — default 2 — virtual-channel id width.
- `PORTW` — default 5 — select vector width; only bits [1:0] are meaningful.
- `CNTW` — default 16 — forwarded-flit counter width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `idata_0` in DATAW — port 0 flit.
- `ivalid_0` in 1 — port 0 flit valid.
- `ivch_0` in VCHW — port 0 virtual channel.
- `idata_1` in DATAW — port 1 flit.
- `ivalid_1` in 1 — port 1 flit valid.
- `ivch_1` in VCHW — port 1 virtual channel.
- `sel` in PORTW — one-hot select; bit0 selects port 0, bit1 selects port 1.
- `odata` out DATAW — selected flit, registered.
- `ovalid` out 1 — selected valid, registered.
- `ovch` out VCHW — selected virtual channel, registered.
- `sel_err` out 1 — registered flag: `sel[1:0]` was 2'b11 in the previous cycle.
- `flit_cnt` out CNTW — count of cycles in which `ovalid` was loaded as 1.

## Operation
- `sel[1:0]` decode:
  - 2'b01 → forward port 0.
  - 2'b10 → forward port 1.
  - 2'b00 → forward nothing: data/vch = 0, valid = 0.
  - 2'b11 → forward port 0 (port 0 has priority) and set `sel_err` for that cycle.
- `sel[PORTW-1:2]` is ignored.
- The data, valid and vch fields of a flit always come from the same port. Fields are never mixed across ports.
- If the selected port's valid is 0, its data and vch still pass through unchanged. Downstream logic qualifies them with `ovalid`.
- `flit_cnt` increments by 1 on each edge where the new `ovalid` is 1. It wraps modulo 2^CNTW.
- No flow control and no buffering: one flit in, one flit out per cycle.

## Timing
- Latency: exactly 1 cycle. Inputs and `sel` sampled at edge N appear on the outputs after edge N.
- Reset, with `rst` = 1 at an edge:
  - `odata` = 0, `ovalid` = 0, `ovch` = 0, `sel_err` = 0, `flit_cnt` = 0.
  - Reset overrides all other behaviour for that edge.
- Reset mid-packet: the flit sampled at the reset edge is dropped. Forwarding resumes at the first edge with `rst` = 0.
- `sel` may change on any cycle, including mid-packet. The new selection takes effect for the flit sampled at that same edge, with no bubble.
- `sel_err` is held for exactly one cycle per offending sample.

## Structure
- A shared NoC package holds:
  - `DATAW`, `VCHW` and `PORTW` defaults;
  - flit-type encodings: NONE = 2'b00, HEAD, DATA, TAIL;
  - Enable/Disable constants.
- One sub-module, `mux_sel_decode`: combinational one-hot to (port index, none, error).
- The top level contains the decode instance, the output registers and the counter.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with active inputs → all outputs 0, `flit_cnt` = 0.
- Port 1 packet:
  - Stimulus: `sel` = 5'b00010; port 1 sends HEAD, 20 DATA flits and a TAIL with valid = 1; port 0 sends concurrently.
  - Required response: `odata` equals the port 1 flit one cycle later; `ovch` = `ivch_1`; `flit_cnt` = 22 after the packet.
- Idle gaps: repeat the packet 10 times with 7 idle cycles (valid = 0) between packets → `ovalid` = 0 during the gaps; `flit_cnt` = 220.
- Port 0 with mid-packet switch: `sel` = 5'b00001, then switch to 5'b00010 mid-packet → output changes source on the cycle after the switch, with no dropped or duplicated cycle.
- Illegal and empty select:
  - `sel` = 5'b00011 → port 0 forwarded; `sel_err` = 1 for one cycle.
  - `sel` = 5'b00000 → `ovalid` = 0, `odata` = 0.
  - `sel` = 5'b10110 → treated as 2'b10.
- Counter wrap and reset: preload `flit_cnt` to its maximum with `CNTW` = 4, send 2 valid flits → `flit_cnt` = 1. Assert `rst` mid-packet → outputs 0 on the next cycle.
